// File: rtl/store_request_unit.sv
// store_request_unit: MEM-stage store path building strobes/lane data and driving the data-SRAM bus.
// Optional STORE_ALIGN_CHECK_EN raises st_ades for misaligned SH/SW instead of silently aligning.
module store_request_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid_EXE,
    output logic              st_ready_EXE,
    input  logic [2:0]        st_op_EXE,
    input  logic [ADDR_W-1:0] st_addr_EXE,
    input  logic [DATA_W-1:0] st_data_EXE,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    output logic              st_done,
    output logic              st_ades,
    output logic [ADDR_W-1:0] st_badvaddr,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state, state_next;
    logic accept, reserved, fault;
    logic [1:0] a;
    logic [1:0] size_n;
    logic [3:0] wstrb_n;
    logic [DATA_W-1:0] wdata_n;
    logic [ADDR_W-1:0] addr_n;

    assign data_req     = state == REQ;
    assign data_wr      = data_req;
    assign st_ready_EXE = state == IDLE;
    assign busy         = state != IDLE;

    always_comb begin
        a        = st_addr_EXE[1:0];
        accept   = st_valid_EXE & (state == IDLE);
        reserved = st_op_EXE > 3'd4;
`ifdef STORE_ALIGN_CHECK_EN
        fault    = (st_op_EXE == 3'd1 & a[0]) | (st_op_EXE == 3'd2 & a != 2'd0);
`else
        fault    = 1'b0;
`endif
        state_next = state;
        case (state)
            IDLE:    state_next = (accept & ~reserved & ~fault) ? REQ : IDLE;
            REQ:     state_next = data_addr_ok ? WAIT : REQ;
            WAIT:    state_next = data_data_ok ? IDLE : WAIT;
            default: state_next = IDLE;
        endcase
        size_n  = 2'd2;
        wstrb_n = 4'b1111;
        wdata_n = st_data_EXE;
        addr_n  = {st_addr_EXE[ADDR_W-1:2], 2'b00};
        // SWL keeps the high bytes of rt in the low lanes; SWR the reverse.
        case (st_op_EXE)
            3'd0: begin
                size_n  = 2'd0;
                wstrb_n = 4'b0001 << a;
                wdata_n = {4{st_data_EXE[7:0]}};
                addr_n  = st_addr_EXE;
            end
            3'd1: begin
                size_n  = 2'd1;
                wstrb_n = a[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{st_data_EXE[15:0]}};
                addr_n  = {st_addr_EXE[ADDR_W-1:1], 1'b0};
            end
            3'd3: begin
                wstrb_n = 4'b1111 >> ~a;
                wdata_n = st_data_EXE >> {~a, 3'b000};
            end
            3'd4: begin
                wstrb_n = 4'b1111 << a;
                wdata_n = st_data_EXE << {a, 3'b000};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            data_addr   <= '0;
            data_size   <= '0;
            data_wstrb  <= '0;
            data_wdata  <= '0;
            st_done     <= 1'b0;
            st_ades     <= 1'b0;
            st_badvaddr <= '0;
        end else begin
            state   <= state_next;
            st_done <= (state == WAIT & data_data_ok) | (accept & reserved);
            st_ades <= accept & fault;
            if (accept & fault)
                st_badvaddr <= st_addr_EXE;
            if (accept & ~reserved & ~fault) begin
                data_addr  <= addr_n;
                data_size  <= size_n;
                data_wstrb <= wstrb_n;
                data_wdata <= wdata_n;
            end
        end
    end
endmodule

// File: tb/tb_store_request_unit.sv
// tb_store_request_unit: directed store vectors with hand-computed bus fields and handshake timing.
module tb_store_request_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        st_valid_EXE = 1'b0;
    logic        st_ready_EXE;
    logic [2:0]  st_op_EXE = '0;
    logic [31:0] st_addr_EXE = '0;
    logic [31:0] st_data_EXE = '0;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, st_badvaddr;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic        st_done, st_ades, busy;
    int checks = 0;
    int errors = 0;

    store_request_unit dut (
        .clk(clk), .rst(rst),
        .st_valid_EXE(st_valid_EXE), .st_ready_EXE(st_ready_EXE),
        .st_op_EXE(st_op_EXE), .st_addr_EXE(st_addr_EXE), .st_data_EXE(st_data_EXE),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .st_done(st_done), .st_ades(st_ades), .st_badvaddr(st_badvaddr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rt);
        st_valid_EXE = 1'b1;
        st_op_EXE    = op;
        st_addr_EXE  = addr;
        st_data_EXE  = rt;
        step();
        st_valid_EXE = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!st_done && n < 20) begin
            step();
            n++;
        end
        chk(tag, {31'b0, st_done}, 32'd1);
    endtask

    task automatic fields(input string tag, input logic [31:0] addr, input logic [3:0] wstrb,
                          input logic [31:0] wdata, input logic [1:0] size);
        chk({tag, "_req"}, {31'b0, data_req}, 32'd1);
        chk({tag, "_wr"}, {31'b0, data_wr}, 32'd1);
        chk({tag, "_addr"}, data_addr, addr);
        chk({tag, "_wstrb"}, {28'b0, data_wstrb}, {28'b0, wstrb});
        chk({tag, "_wdata"}, data_wdata, wdata);
        chk({tag, "_size"}, {30'b0, data_size}, {30'b0, size});
    endtask

    task automatic idle_zero(input string tag);
        chk({tag, "_req"}, {31'b0, data_req}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_ready"}, {31'b0, st_ready_EXE}, 32'd1);
        chk({tag, "_addr"}, data_addr, 32'd0);
        chk({tag, "_wdata"}, data_wdata, 32'd0);
        chk({tag, "_wstrb"}, {28'b0, data_wstrb}, 32'd0);
        chk({tag, "_size"}, {30'b0, data_size}, 32'd0);
        chk({tag, "_done"}, {31'b0, st_done}, 32'd0);
        chk({tag, "_ades"}, {31'b0, st_ades}, 32'd0);
        chk({tag, "_bad"}, st_badvaddr, 32'd0);
    endtask

    initial begin
        step();
        step();
        idle_zero("rst");
        rst = 1'b1;
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;

        issue(3'd0, 32'h1003, 32'h112233AA);
        fields("sb", 32'h1003, 4'b1000, 32'hAAAAAAAA, 2'd0);
        step();
        chk("sb_wait_req", {31'b0, data_req}, 32'd0);
        chk("sb_wait_busy", {31'b0, busy}, 32'd1);
        step();
        chk("sb_done_n3", {31'b0, st_done}, 32'd1);
        chk("sb_ready_n3", {31'b0, st_ready_EXE}, 32'd1);
        step();
        chk("sb_done_1cyc", {31'b0, st_done}, 32'd0);

        issue(3'd3, 32'h2001, 32'hDEADBEEF);
        fields("swl", 32'h2000, 4'b0011, 32'h0000DEAD, 2'd2);
        wait_done("swl_done");
        issue(3'd4, 32'h2001, 32'hDEADBEEF);
        fields("swr", 32'h2000, 4'b1110, 32'hADBEEF00, 2'd2);
        wait_done("swr_done");
        issue(3'd3, 32'h2003, 32'hDEADBEEF);
        fields("swl3", 32'h2000, 4'b1111, 32'hDEADBEEF, 2'd2);
        wait_done("swl3_done");
        issue(3'd4, 32'h2003, 32'hDEADBEEF);
        fields("swr3", 32'h2000, 4'b1000, 32'hEF000000, 2'd2);
        wait_done("swr3_done");

        data_addr_ok = 1'b0;
        issue(3'd1, 32'h3002, 32'h0000CAFE);
        for (int i = 0; i < 6; i++) begin
            fields("sh_stall", 32'h3002, 4'b1100, 32'hCAFECAFE, 2'd1);
            chk("sh_stall_ready", {31'b0, st_ready_EXE}, 32'd0);
            chk("sh_stall_done", {31'b0, st_done}, 32'd0);
            if (i == 5) data_addr_ok = 1'b1;
            step();
        end
        chk("sh_wait_req", {31'b0, data_req}, 32'd0);
        wait_done("sh_done");

        issue(3'd2, 32'h4002, 32'h01020304);
`ifdef STORE_ALIGN_CHECK_EN
        chk("sw_mis_req", {31'b0, data_req}, 32'd0);
        chk("sw_mis_ades", {31'b0, st_ades}, 32'd1);
        chk("sw_mis_bad", st_badvaddr, 32'h4002);
        chk("sw_mis_done", {31'b0, st_done}, 32'd0);
        step();
        chk("sw_mis_ades_1cyc", {31'b0, st_ades}, 32'd0);
        chk("sw_mis_req2", {31'b0, data_req}, 32'd0);
`else
        fields("sw_mis", 32'h4000, 4'b1111, 32'h01020304, 2'd2);
        chk("sw_mis_ades", {31'b0, st_ades}, 32'd0);
        wait_done("sw_mis_done");
        chk("sw_mis_bad", st_badvaddr, 32'd0);
`endif

        data_data_ok = 1'b0;
        issue(3'd0, 32'h5001, 32'h00000055);
        step();
        chk("rstw_busy", {31'b0, busy}, 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        data_data_ok = 1'b1;
        idle_zero("rstw");
        step();
        chk("rstw_stray_done", {31'b0, st_done}, 32'd0);
        chk("rstw_stray_busy", {31'b0, busy}, 32'd0);

        st_valid_EXE = 1'b1;
        st_op_EXE    = 3'd0;
        st_addr_EXE  = 32'h6000;
        st_data_EXE  = 32'h00000001;
        step();
        step();
        step();
        chk("b2b_done", {31'b0, st_done}, 32'd1);
        chk("b2b_ready", {31'b0, st_ready_EXE}, 32'd1);
        st_op_EXE   = 3'd2;
        st_addr_EXE = 32'h6004;
        st_data_EXE = 32'h12345678;
        step();
        st_valid_EXE = 1'b0;
        fields("b2b2", 32'h6004, 4'b1111, 32'h12345678, 2'd2);
        wait_done("b2b2_done");

        issue(3'd7, 32'h7000, 32'hFFFFFFFF);
        chk("rsv_done", {31'b0, st_done}, 32'd1);
        chk("rsv_req", {31'b0, data_req}, 32'd0);
        chk("rsv_busy", {31'b0, busy}, 32'd0);
        step();
        chk("rsv_done_1cyc", {31'b0, st_done}, 32'd0);
        chk("rsv_req2", {31'b0, data_req}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
